dense_out: RTL and testbench

DENSE_OUT -- requirements
Module: dense_out

---
 rtl/dense_pkg.sv | 20 ++
 rtl/dense_mac.sv | 33 +++
 rtl/dense_out.sv | 156 +++++++++++++++
 tb/tb_dense_out.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// Shared types and constants for the dense output layer: FSM states,
// memory read latency and the overflow-free accumulator width.
package dense_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int MEM_LAT = 2;

    // Full product width plus enough headroom to sum in_len products.
    function automatic int acc_width(input int size, input int in_len);
        return 2 * size + $clog2(in_len) + 1;
    endfunction

endpackage

// File: rtl/dense_mac.sv
// Signed multiply-accumulate: a valid beat with clear set loads the product
// directly, so a new neuron starts without an idle cycle.
module dense_mac
#(
    parameter int SIZE = 11,
    parameter int AW   = 28
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 valid,
    input  logic signed [SIZE-1:0] a,
    input  logic signed [SIZE-1:0] b,
    output logic signed [AW-1:0]   acc
);

    logic signed [2*SIZE-1:0] prod;
    logic signed [AW-1:0]     prod_x;

    assign prod   = a * b;
    assign prod_x = AW'(prod);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (valid) begin
            acc <= clear ? prod_x : acc + prod_x;
        end else if (clear) begin
            acc <= '0;
        end
    end

endmodule

// File: rtl/dense_out.sv
// Fully-connected output layer: streams IN_LEN feature/weight pairs per neuron,
// accumulates, shifts and writes OUT_LEN scores. DENSE_SAT_EN selects saturation.
module dense_out
    import dense_pkg::*;
#(
    parameter int SIZE             = 11,
    parameter int SIZE_address_pix = 13,
    parameter int SIZE_address_wei = 13,
    parameter int IN_LEN           = 32,
    parameter int OUT_LEN          = 11,
    parameter int SHIFT            = 8
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [SIZE_address_pix-1:0] memstartp,
    input  logic [SIZE_address_wei-1:0] memstartw,
    input  logic [SIZE_address_pix-1:0] memstartzap,
    output logic [SIZE_address_pix-1:0] read_addressp,
    output logic [SIZE_address_wei-1:0] read_addressw,
    input  logic [SIZE-1:0]             qp,
    input  logic [SIZE-1:0]             qw,
    output logic                        re,
    output logic [SIZE_address_pix-1:0] write_addressp,
    output logic [SIZE-1:0]             dp,
    output logic                        we,
    output logic                        STOP,
    output logic [2:0]                  dbg_state
);

    localparam int AW = acc_width(SIZE, IN_LEN);
    localparam int IW = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
    localparam int JW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
    localparam int PW = SIZE_address_pix;
    localparam int WW = SIZE_address_wei;
    localparam int PL = MEM_LAT - 1;

    state_t state, next_state;

    logic [IW-1:0] i;
    logic [JW-1:0] j;
    logic [1:0]    dcnt;
    logic [PW-1:0] pbase, zbase;
    logic [WW-1:0] wbase;
    logic [PL-1:0] vpipe, fpipe;
    logic          last_i, last_j, last_d;

    logic signed [AW-1:0] acc, shifted;
    logic [SIZE-1:0]      dres;

    assign last_i    = (i == IW'(IN_LEN - 1));
    assign last_j    = (j == JW'(OUT_LEN - 1));
    assign last_d    = (dcnt == 2'(MEM_LAT - 1));
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable) next_state = ISSUE;
            ISSUE:   if (last_i) next_state = DRAIN;
            DRAIN:   if (last_d) next_state = WRITE;
            WRITE:   next_state = last_j ? DONE : ISSUE;
            DONE:    next_state = DONE;
            default: next_state = IDLE;
        endcase
        if (!enable) next_state = IDLE;
    end

    // Counters, captured bases and the valid/first tags that follow each
    // read request through the memory latency.
    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            i     <= '0;
            j     <= '0;
            dcnt  <= '0;
            pbase <= '0;
            wbase <= '0;
            zbase <= '0;
            vpipe <= '0;
            fpipe <= '0;
        end else begin
            if (state == IDLE) begin
                pbase <= memstartp;
                wbase <= memstartw;
                zbase <= memstartzap;
            end
            if (state == ISSUE) i <= last_i ? '0 : i + 1'b1;
            dcnt <= (state == DRAIN) ? dcnt + 2'd1 : 2'd0;
            if (state == WRITE && !last_j) j <= j + 1'b1;
            vpipe[0] <= (state == ISSUE);
            fpipe[0] <= (state == ISSUE) && (i == '0);
            for (int k = 1; k < PL; k++) begin
                vpipe[k] <= vpipe[k-1];
                fpipe[k] <= fpipe[k-1];
            end
        end
    end

    dense_mac #(.SIZE(SIZE), .AW(AW)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (fpipe[PL-1] | ~enable),
        .valid (vpipe[PL-1] & enable),
        .a     (qp),
        .b     (qw),
        .acc   (acc)
    );

    assign shifted = acc >>> SHIFT;

`ifdef DENSE_SAT_EN
    localparam logic signed [AW-1:0] SMAX = AW'(2 ** (SIZE - 1) - 1);
    localparam logic signed [AW-1:0] SMIN = ~SMAX;

    always_comb begin
        dres = SIZE'(shifted);
        if (shifted > SMAX)      dres = SIZE'(SMAX);
        else if (shifted < SMIN) dres = SIZE'(SMIN);
    end
`else
    assign dres = SIZE'(shifted);
`endif

    always_comb begin
        re             = 1'b0;
        we             = 1'b0;
        STOP           = 1'b0;
        read_addressp  = '0;
        read_addressw  = '0;
        write_addressp = '0;
        dp             = '0;
        case (state)
            ISSUE: begin
                re            = 1'b1;
                read_addressp = pbase + PW'(i);
                read_addressw = wbase + WW'(j) * WW'(IN_LEN) + WW'(i);
            end
            WRITE: begin
                we             = 1'b1;
                write_addressp = zbase + PW'(j);
                dp             = dres;
            end
            DONE:    STOP = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dense_out.sv
// Bench for dense_out: directed table, random layers against a sum-of-products
// model, abort, mid-layer reset and DONE hold. Works with or without DENSE_SAT_EN.
module tb_dense_out;

    localparam int IN_LEN  = 4;
    localparam int OUT_LEN = 2;
    localparam int LAT     = OUT_LEN * (IN_LEN + 3);

    typedef struct packed {
        int k;
        int f0, f1, f2, f3;
        int w0, w1, w2, w3, w4, w5, w6, w7;
        int e0, e1, s0, s1;
    } vec_t;

    logic        clk, rst_n;
    logic        en[2];
    logic [12:0] mp[2], mw[2], mz[2], rap[2], raw[2], wap[2];
    logic [10:0] qp[2], qw[2], dp[2];
    logic        re[2], we[2], stop[2];
    logic [2:0]  dbg[2];

    logic [10:0] fmem[0:8191];
    logic [10:0] wmem[0:8191];
    logic [23:0] exp_q[$];
    logic [23:0] got0[$], got1[$];

    int   cur_f[4];
    int   cur_w[8];
    int   nvec, nerr;
    vec_t tbl[5];

    dense_out #(.SIZE(11), .SIZE_address_pix(13), .SIZE_address_wei(13),
                .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .SHIFT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .enable(en[0]),
        .memstartp(mp[0]), .memstartw(mw[0]), .memstartzap(mz[0]),
        .read_addressp(rap[0]), .read_addressw(raw[0]),
        .qp(qp[0]), .qw(qw[0]), .re(re[0]),
        .write_addressp(wap[0]), .dp(dp[0]), .we(we[0]),
        .STOP(stop[0]), .dbg_state(dbg[0])
    );

    dense_out #(.SIZE(11), .SIZE_address_pix(13), .SIZE_address_wei(13),
                .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .SHIFT(2)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(en[1]),
        .memstartp(mp[1]), .memstartw(mw[1]), .memstartzap(mz[1]),
        .read_addressp(rap[1]), .read_addressw(raw[1]),
        .qp(qp[1]), .qw(qw[1]), .re(re[1]),
        .write_addressp(wap[1]), .dp(dp[1]), .we(we[1]),
        .STOP(stop[1]), .dbg_state(dbg[1])
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: address presented after edge N, data visible for edge N+2
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            qp[k] <= fmem[rap[k]];
            qw[k] <= wmem[raw[k]];
        end
    end

    always @(negedge clk) begin
        if (we[0]) got0.push_back({wap[0], dp[0]});
        if (we[1]) got1.push_back({wap[1], dp[1]});
    end

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // reference model: plain dot product, arithmetic shift, then wrap or clamp
    function automatic int ref_score(input int sum, input int sh);
        int s;
        s = sum >>> sh;
`ifdef DENSE_SAT_EN
        if (s > 1023) s = 1023;
        if (s < -1024) s = -1024;
`else
        s = s & 2047;
        if (s >= 1024) s = s - 2048;
`endif
        return s;
    endfunction

    task automatic load_mem(input int pb, input int wb);
        for (int i = 0; i < 4; i++) fmem[pb + i] = 11'(cur_f[i]);
        for (int i = 0; i < 8; i++) wmem[wb + i] = 11'(cur_w[i]);
    endtask

    task automatic model_exp(input int zb, input int sh, input int nneur);
        int sum;
        for (int j = 0; j < nneur; j++) begin
            sum = 0;
            for (int i = 0; i < IN_LEN; i++) sum += cur_f[i] * cur_w[j * IN_LEN + i];
            exp_q.push_back({13'(zb + j), 11'(ref_score(sum, sh))});
        end
    endtask

    task automatic row_to_cur(input int t);
        cur_f = '{tbl[t].f0, tbl[t].f1, tbl[t].f2, tbl[t].f3};
        cur_w = '{tbl[t].w0, tbl[t].w1, tbl[t].w2, tbl[t].w3,
                  tbl[t].w4, tbl[t].w5, tbl[t].w6, tbl[t].w7};
    endtask

    task automatic kick(input int k, input int pb, input int wb, input int zb);
        mp[k] = 13'(pb);
        mw[k] = 13'(wb);
        mz[k] = 13'(zb);
        en[k] = 1'b1;
    endtask

    // counts edges from the one that enters ISSUE until STOP is seen
    task automatic wait_done(input int k);
        int n;
        n = 0;
        while (n < 200) begin
            @(posedge clk); #1;
            n++;
            if (stop[k]) break;
        end
        check("stop_seen", int'(stop[k]), 1);
        check("latency", n, LAT + 1);
    endtask

    task automatic check_writes(input int k);
        logic [23:0]        e, g;
        logic signed [10:0] gd, ed;
        int                 extra;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if ((k == 0 && got0.size() == 0) || (k == 1 && got1.size() == 0)) begin
                nvec++;
                nerr++;
                $display("FAIL missing_write: got none, expected addr %0d", e[23:11]);
            end else begin
                if (k == 0) g = got0.pop_front();
                else        g = got1.pop_front();
                gd = g[10:0];
                ed = e[10:0];
                check("wr_addr", int'(g[23:11]), int'(e[23:11]));
                check("wr_data", int'(gd), int'(ed));
            end
        end
        extra = (k == 0) ? got0.size() : got1.size();
        check("extra_writes", extra, 0);
        got0.delete();
        got1.delete();
    endtask

    task automatic check_quiet(input int k);
        check("q_re", int'(re[k]), 0);
        check("q_we", int'(we[k]), 0);
        check("q_stop", int'(stop[k]), 0);
        check("q_dp", int'(dp[k]), 0);
        check("q_rap", int'(rap[k]), 0);
        check("q_raw", int'(raw[k]), 0);
        check("q_wap", int'(wap[k]), 0);
    endtask

    task automatic release_en(input int k);
        en[k] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int k, pb, wb, zb;
        nvec  = 0;
        nerr  = 0;
        rst_n = 1'b0;
        for (int q = 0; q < 2; q++) begin
            en[q] = 1'b0;
            mp[q] = '0;
            mw[q] = '0;
            mz[q] = '0;
        end
        for (int a = 0; a < 8192; a++) begin
            fmem[a] = 11'($urandom);
            wmem[a] = 11'($urandom);
        end

        // k, features, weights (neuron-major), expected wrap e0/e1, saturated s0/s1
        tbl[0] = '{0, 1, 2, 3, 4, 1, 1, 1, 1, -1, 0, 0, 2, 10, 7, 10, 7};
        tbl[1] = '{0, 500, 500, 500, 0, 1, 1, 1, 0, -1, -1, -1, -1, -548, 548, 1023, -1024};
        tbl[2] = '{0, -3, 5, 0, 7, 2, -4, 9, 1, 0, 0, 0, 0, -19, 0, -19, 0};
        tbl[3] = '{0, 1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023,
                   -1024, -1024, -1024, -1024, 4, 0, 1023, -1024};
        tbl[4] = '{1, -7, 0, 0, 0, 1, 0, 0, 0, -1, 0, 0, 0, -2, 1, -2, 1};

        repeat (3) @(posedge clk);
        #1;
        check_quiet(0);
        check("rst_stop1", int'(stop[1]), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 5; t++) begin
            k  = tbl[t].k;
            pb = 16 * t;
            wb = 1000 + 32 * t;
            zb = 6000 + 8 * t;
            row_to_cur(t);
            load_mem(pb, wb);
`ifdef DENSE_SAT_EN
            exp_q.push_back({13'(zb), 11'(tbl[t].s0)});
            exp_q.push_back({13'(zb + 1), 11'(tbl[t].s1)});
`else
            exp_q.push_back({13'(zb), 11'(tbl[t].e0)});
            exp_q.push_back({13'(zb + 1), 11'(tbl[t].e1)});
`endif
            kick(k, pb, wb, zb);
            wait_done(k);
            check_writes(k);
            release_en(k);
        end

        for (int n = 0; n < 12; n++) begin
            k  = n % 2;
            pb = $urandom_range(0, 4000);
            wb = $urandom_range(0, 4000);
            zb = $urandom_range(4100, 8000);
            for (int i = 0; i < 4; i++) cur_f[i] = $urandom_range(0, 2047) - 1024;
            for (int i = 0; i < 8; i++) cur_w[i] = $urandom_range(0, 2047) - 1024;
            load_mem(pb, wb);
            model_exp(zb, (k == 1) ? 2 : 0, OUT_LEN);
            kick(k, pb, wb, zb);
            wait_done(k);
            check_writes(k);
            release_en(k);
        end

        // abort during ISSUE of neuron 1: only the first score may appear
        row_to_cur(0);
        load_mem(100, 200);
        model_exp(300, 0, 1);
        kick(0, 100, 200, 300);
        repeat (9) @(posedge clk);
        #1;
        check("abort_in_issue", int'(re[0]), 1);
        en[0] = 1'b0;
        @(posedge clk); #1;
        check_quiet(0);
        repeat (3) @(posedge clk);
        #1;
        check_writes(0);
        model_exp(300, 0, OUT_LEN);
        kick(0, 100, 200, 300);
        wait_done(0);
        check_writes(0);
        release_en(0);

        // one-cycle reset in DRAIN of neuron 0 with enable held high
        model_exp(300, 0, OUT_LEN);
        kick(0, 100, 200, 300);
        repeat (5) @(posedge clk);
        #1;
        check("drain_no_re", int'(re[0]), 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_quiet(0);
        rst_n = 1'b1;
        wait_done(0);
        check_writes(0);

        // hold in DONE for 20 cycles, then release
        for (int c = 0; c < 20; c++) begin
            check("hold_stop", int'(stop[0]), 1);
            check("hold_we", int'(we[0]), 0);
            @(posedge clk); #1;
        end
        release_en(0);
        check("stop_clear", int'(stop[0]), 0);
        check_writes(0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
